// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA encryption/decryption cores: FSM states,
// default operand widths and the expected-latency helper.
package rsa_pkg;

    localparam int WIDTH_N_DEF   = 8;
    localparam int WIDTH_DEG_DEF = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SQR  = 3'd2,
        MUL  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Edge index after which down is high, counted from the accepting edge E0.
    function automatic int expected_latency(input int width_n, input int width_deg,
                                            input logic [31:0] d_val);
        int pop;
        pop = 0;
        for (int i = 0; i < width_deg; i++) begin
            if (d_val[i]) begin
                pop = pop + 1;
            end
        end
        return 2 + width_n * (width_deg + pop);
    endfunction

endpackage

// File: rtl/mod_mult.sv
// Bit-serial interleaved modular multiplier: result = a*b mod m in WIDTH_N
// cycles (launch edge included), scanning b MSB first.
module mod_mult #(
    parameter int WIDTH_N = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH_N-1:0] i_a,
    input  logic [WIDTH_N-1:0] i_b,
    input  logic [WIDTH_N-1:0] i_m,
    output logic               o_done,
    output logic [WIDTH_N-1:0] o_result
);

    localparam int CW = $clog2(WIDTH_N + 1);

    logic [WIDTH_N-1:0] r_acc;
    logic [WIDTH_N-1:0] r_a;
    logic [WIDTH_N-1:0] r_b;
    logic [WIDTH_N-1:0] r_m;
    logic [CW-1:0]      r_cnt;
    logic               r_run;
    logic [WIDTH_N-1:0] w_first;
    logic [WIDTH_N-1:0] w_next;

    // One interleaved step; acc < m and a < m keep every intermediate below 2m.
    function automatic logic [WIDTH_N-1:0] mm_step(input logic [WIDTH_N-1:0] acc,
                                                   input logic [WIDTH_N-1:0] a,
                                                   input logic [WIDTH_N-1:0] m,
                                                   input logic               b_bit);
        logic [WIDTH_N:0] t;
        t = {acc, 1'b0};
        if (t >= {1'b0, m}) begin
            t = t - {1'b0, m};
        end
        if (b_bit) begin
            t = t + {1'b0, a};
        end
        if (t >= {1'b0, m}) begin
            t = t - {1'b0, m};
        end
        return t[WIDTH_N-1:0];
    endfunction

    assign w_first  = mm_step({WIDTH_N{1'b0}}, i_a, i_m, i_b[WIDTH_N-1]);
    assign w_next   = mm_step(r_acc, r_a, r_m, r_b[WIDTH_N-1]);
    assign o_done   = r_run && (r_cnt == CW'(1));
    assign o_result = w_next;

    // Launch consumes the MSB directly so the last bit lands on the N-th edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= {WIDTH_N{1'b0}};
            r_a   <= {WIDTH_N{1'b0}};
            r_b   <= {WIDTH_N{1'b0}};
            r_m   <= {WIDTH_N{1'b0}};
            r_cnt <= {CW{1'b0}};
            r_run <= 1'b0;
        end else if (i_start && !r_run) begin
            r_acc <= w_first;
            r_a   <= i_a;
            r_b   <= {i_b[WIDTH_N-2:0], 1'b0};
            r_m   <= i_m;
            r_cnt <= CW'(WIDTH_N - 1);
            r_run <= 1'b1;
        end else if (r_run) begin
            r_acc <= w_next;
            r_b   <= {r_b[WIDTH_N-2:0], 1'b0};
            r_cnt <= r_cnt - CW'(1);
            r_run <= (r_cnt != CW'(1));
        end else begin
            r_run <= 1'b0;
        end
    end

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption core: out = cipher^d mod n by left-to-right square-and-multiply,
// with all modular products taken from the shared bit-serial multiplier.
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter int WIDTH_N   = WIDTH_N_DEF,
    parameter int WIDTH_DEG = WIDTH_DEG_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH_N-1:0]   cipher,
    input  logic [WIDTH_DEG-1:0] d,
    input  logic [WIDTH_N-1:0]   n,
    output logic [WIDTH_N-1:0]   out,
    output logic                 busy,
    output logic                 down,
    output logic                 err
);

    localparam int KW = (WIDTH_DEG > 1) ? $clog2(WIDTH_DEG) : 1;

    state_t               r_state;
    logic [WIDTH_N-1:0]   r_c;
    logic [WIDTH_N-1:0]   r_n;
    logic [WIDTH_N-1:0]   r_r;
    logic [WIDTH_DEG-1:0] r_d;
    logic [KW-1:0]        r_k;
    logic                 r_launch;
    logic [WIDTH_N-1:0]   r_out;
    logic                 r_busy;
    logic                 r_down;
    logic                 r_err;
    logic [WIDTH_N-1:0]   w_mm_b;
    logic                 w_mm_done;
    logic [WIDTH_N-1:0]   w_mm_res;

    assign out  = r_out;
    assign busy = r_busy;
    assign down = r_down;
    assign err  = r_err;

    // Multiplier second operand: ciphertext in MUL, the running result when squaring.
    always_comb begin
        if (r_state == MUL) begin
            w_mm_b = r_c;
        end else begin
            w_mm_b = r_r;
        end
    end

    mod_mult #(.WIDTH_N(WIDTH_N)) u_mod_mult (
        .clk     (clk),
        .rst     (rst),
        .i_start (r_launch),
        .i_a     (r_r),
        .i_b     (w_mm_b),
        .i_m     (r_n),
        .o_done  (w_mm_done),
        .o_result(w_mm_res)
    );

    // Control FSM; r_launch marks the first cycle of SQR/MUL when the multiplier starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_c      <= {WIDTH_N{1'b0}};
            r_n      <= {WIDTH_N{1'b0}};
            r_r      <= {WIDTH_N{1'b0}};
            r_d      <= {WIDTH_DEG{1'b0}};
            r_k      <= {KW{1'b0}};
            r_launch <= 1'b0;
            r_out    <= {WIDTH_N{1'b0}};
            r_busy   <= 1'b0;
            r_down   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_down <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_c     <= cipher;
                        r_d     <= d;
                        r_n     <= n;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                LOAD: begin
                    if ((r_n < WIDTH_N'(2)) || (r_c >= r_n)) begin
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_r      <= WIDTH_N'(1);
                        r_k      <= KW'(WIDTH_DEG - 1);
                        r_launch <= 1'b1;
                        r_state  <= SQR;
                    end
                end
                SQR: begin
                    if (r_launch) begin
                        r_launch <= 1'b0;
                    end else if (w_mm_done) begin
                        r_r <= w_mm_res;
                        if (r_d[r_k]) begin
                            r_launch <= 1'b1;
                            r_state  <= MUL;
                        end else if (r_k == {KW{1'b0}}) begin
                            r_state <= DONE;
                        end else begin
                            r_k      <= r_k - KW'(1);
                            r_launch <= 1'b1;
                        end
                    end else begin
                        r_launch <= 1'b0;
                    end
                end
                MUL: begin
                    if (r_launch) begin
                        r_launch <= 1'b0;
                    end else if (w_mm_done) begin
                        r_r <= w_mm_res;
                        if (r_k == {KW{1'b0}}) begin
                            r_state <= DONE;
                        end else begin
                            r_k      <= r_k - KW'(1);
                            r_launch <= 1'b1;
                            r_state  <= SQR;
                        end
                    end else begin
                        r_launch <= 1'b0;
                    end
                end
                DONE: begin
                    r_down  <= 1'b1;
                    r_out   <= r_err ? {WIDTH_N{1'b0}} : r_r;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_decrypt.sv
// Self-checking bench for rsa_decrypt: scoreboard of reference results and latencies.
module tb_rsa_decrypt;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] cipher;
    logic [7:0] d;
    logic [7:0] n;
    logic [7:0] out;
    logic       busy;
    logic       down;
    logic       err;

    typedef struct {
        logic [7:0] out;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   fails;

    rsa_decrypt #(.WIDTH_N(8), .WIDTH_DEG(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cipher(cipher),
        .d     (d),
        .n     (n),
        .out   (out),
        .busy  (busy),
        .down  (down),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input int c, input int dv, input int nv);
        exp_t e;
        int   r;
        e.lat = 2 + 8 * (8 + $countones(dv[7:0]));
        if (nv < 2 || c >= nv) begin
            e.out = 8'd0;
            e.err = 1'b1;
            e.lat = 2;
        end else begin
            r = 1;
            for (int i = 7; i >= 0; i--) begin
                r = (r * r) % nv;
                if (dv[i]) r = (r * c) % nv;
            end
            e.out = r[7:0];
            e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic drive_start(input int c, input int dv, input int nv);
        @(negedge clk);
        cipher = c[7:0];
        d      = dv[7:0];
        n      = nv[7:0];
        start  = 1'b1;
        sb.push_back(model(c, dv, nv));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_down(input int lat_in, output int lat, output logic [7:0] o,
                             output logic e, output logic to);
        lat = lat_in;
        to  = 1'b0;
        while (!down && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        to = !down;
        o  = out;
        e  = err;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cipher = 8'd0; d = 8'd0; n = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (out !== 8'd0) begin fails++; $display("FAIL reset_out got %0d exp 0", out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
        tests++; if (down !== 1'b0) begin fails++; $display("FAIL reset_down got %0b exp 0", down); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %0b exp 0", err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat; logic [7:0] o; logic e; logic to; exp_t x;
        drive_start(31, 7, 33);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_rise got %0b exp 1", busy); end
        wait_down(0, lat, o, e, to);
        x = sb.pop_front();
        tests++; if (to || o !== x.out) begin fails++; $display("FAIL basic_out got %0d exp %0d", o, x.out); end
        tests++; if (e !== x.err) begin fails++; $display("FAIL basic_err got %0b exp %0b", e, x.err); end
        tests++; if (lat !== x.lat) begin fails++; $display("FAIL basic_latency got %0d exp %0d", lat, x.lat); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_done got %0b exp 1", busy); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0 || down !== 1'b0) begin fails++; $display("FAIL basic_idle busy %0b down %0b exp 0 0", busy, down); end
    endtask

    task automatic test_vectors;
        int lat; logic [7:0] o; logic e; logic to; exp_t x;
        int cv[3] = '{254, 0, 5};
        int dvv[3] = '{255, 3, 0};
        int nvv[3] = '{255, 33, 33};
        for (int i = 0; i < 3; i++) begin
            drive_start(cv[i], dvv[i], nvv[i]);
            wait_down(0, lat, o, e, to);
            x = sb.pop_front();
            tests++; if (to || o !== x.out) begin fails++; $display("FAIL vec%0d_out got %0d exp %0d", i, o, x.out); end
            tests++; if (e !== x.err) begin fails++; $display("FAIL vec%0d_err got %0b exp %0b", i, e, x.err); end
            tests++; if (lat !== x.lat) begin fails++; $display("FAIL vec%0d_latency got %0d exp %0d", i, lat, x.lat); end
        end
    endtask

    task automatic test_error;
        int lat; logic [7:0] o; logic e; logic to; exp_t x;
        int cv[3] = '{5, 40, 5};
        int dvv[3] = '{7, 7, 0};
        int nvv[3] = '{1, 33, 33};
        for (int i = 0; i < 3; i++) begin
            drive_start(cv[i], dvv[i], nvv[i]);
            wait_down(0, lat, o, e, to);
            x = sb.pop_front();
            tests++; if (to || o !== x.out) begin fails++; $display("FAIL err%0d_out got %0d exp %0d", i, o, x.out); end
            tests++; if (e !== x.err) begin fails++; $display("FAIL err%0d_flag got %0b exp %0b", i, e, x.err); end
            tests++; if (lat !== x.lat) begin fails++; $display("FAIL err%0d_latency got %0d exp %0d", i, lat, x.lat); end
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [7:0] o; logic e; logic to; exp_t x;
        drive_start(31, 7, 33);
        void'(sb.pop_back());
        repeat (29) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++; if (out !== 8'd0 || busy !== 1'b0 || down !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL midreset_outputs out %0d busy %0b down %0b err %0b exp all 0", out, busy, down, err);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (down !== 1'b0) begin fails++; $display("FAIL midreset_down got %0b exp 0", down); end
        @(negedge clk);
        rst = 1'b0;
        drive_start(31, 7, 33);
        wait_down(0, lat, o, e, to);
        x = sb.pop_front();
        tests++; if (to || o !== x.out) begin fails++; $display("FAIL midreset_rerun got %0d exp %0d", o, x.out); end
        tests++; if (lat !== x.lat) begin fails++; $display("FAIL midreset_latency got %0d exp %0d", lat, x.lat); end
    endtask

    task automatic test_start_ignored;
        int lat; logic [7:0] o; logic e; logic to; exp_t x;
        drive_start(31, 7, 33);
        repeat (9) @(posedge clk);
        @(negedge clk);
        cipher = 8'd5; d = 8'd3; n = 8'd35; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_down(10, lat, o, e, to);
        x = sb.pop_front();
        tests++; if (to || o !== x.out) begin fails++; $display("FAIL ignored_out got %0d exp %0d", o, x.out); end
        tests++; if (lat !== x.lat) begin fails++; $display("FAIL ignored_latency got %0d exp %0d", lat, x.lat); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignored_not_queued busy %0b exp 0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [7:0] o; logic e; logic to; exp_t x;
        drive_start(31, 7, 33);
        wait_down(0, lat, o, e, to);
        x = sb.pop_front();
        tests++; if (to || o !== x.out) begin fails++; $display("FAIL b2b_first got %0d exp %0d", o, x.out); end
        drive_start(2, 5, 33);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept busy %0b exp 1", busy); end
        wait_down(0, lat, o, e, to);
        x = sb.pop_front();
        tests++; if (to || o !== x.out) begin fails++; $display("FAIL b2b_second got %0d exp %0d", o, x.out); end
        tests++; if (lat !== x.lat) begin fails++; $display("FAIL b2b_latency got %0d exp %0d", lat, x.lat); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_basic;
        test_vectors;
        test_error;
        test_reset_mid;
        test_start_ignored;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rsa_decrypt.md
# rsa_decrypt

Sequential RSA decryption core: computes out = cipher^d mod n by left-to-right square-and-multiply, with every modular product formed by a bit-serial interleaved modular multiplier. It is the receive-side counterpart of the encryption core. The ciphertext that block produces is fed here together with the private exponent d and the same modulus n. It provides a start/down handshake, data-independent squaring, and an error flag for illegal operands.

## Interface
- WIDTH_N, 8, width of modulus n, ciphertext and result
- WIDTH_DEG, 8, width of private exponent d
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- cipher  in  WIDTH_N  ciphertext; captured when start is accepted
- d  in  WIDTH_DEG  private exponent; captured when start is accepted
- n  in  WIDTH_N  modulus; captured when start is accepted
- out  out  WIDTH_N  plaintext result; holds until the next accepted start
- busy  out  1  high from the cycle after acceptance through the DONE cycle
- down  out  1  one-cycle completion pulse; out and err are valid while it is high
- err  out  1  operand error flag; valid with down

## Operation
- One clock (clk); reset asynchronous, active-high (rst). Reset clears everything: state IDLE, out=0, busy=0, down=0, err=0, all internal registers 0.
- FSM states:
  - IDLE: on start=1, capture cipher, d and n into c_r, d_r and n_r; go to LOAD.
  - LOAD: 1 cycle.
    - If n_r<2 or c_r>=n_r: set err=1, out=0, go to DONE.
    - Otherwise: r=1, bit index k=WIDTH_DEG-1, go to SQR.
  - SQR: launch mod_mult(r, r, n_r) and wait for its result; r <= result.
    - If d_r[k]=1, go to MUL.
    - Else if k=0, go to DONE.
    - Else k<=k-1 and stay in SQR.
  - MUL: launch mod_mult(r, c_r, n_r); r <= result.
    - If k=0, go to DONE.
    - Else k<=k-1 and go to SQR.
  - DONE: 1 cycle. down=1, out=r (or 0 on error), go to IDLE.
- No leading-zero skip: all WIDTH_DEG exponent bits are processed.
- d=0 yields out=1 (n>=2).
- mod_mult(a, b, m), requiring a,b < m, is bit-serial over b, MSB first. For each bit: acc = 2*acc; if acc>=m then acc-=m; if the b bit is set, acc += a; if acc>=m then acc-=m.
- Internal widths: acc is WIDTH_N+1 bits; result < m, WIDTH_N bits. No full-width product is ever formed.
- start while busy: ignored, not queued. Input changes after acceptance have no effect.
- err clears on the next accepted start. down is never high while rst=1.

## Timing
- Edge E0 samples start in IDLE. LOAD executes at E1.
- Each mod_mult takes exactly WIDTH_N cycles, including launch; the result is registered on the last cycle.
- down is high in the cycle following edge E(2 + WIDTH_N*(WIDTH_DEG + popcount(d))). Example: WIDTH_N=8, WIDTH_DEG=8, d=7 gives down after edge E90.
- Error path: down is high after E2.
- busy rises after E0 and falls together with down at the DONE-to-IDLE edge.
- A new start may be asserted in the cycle down is high. It is accepted on the following edge, since the FSM is then in IDLE.
- Reset mid-operation takes effect immediately, asynchronously. No down pulse is produced and any in-flight mod_mult is abandoned.

## Structure
- Shared package rsa_pkg holds:
  - the FSM state enum: IDLE, LOAD, SQR, MUL, DONE;
  - default WIDTH_N/WIDTH_DEG constants, shared with the encryption core;
  - a function computing the expected latency, for benches.
- One sub-module, mod_mult: start/done handshake, parameter WIDTH_N, same clk/rst. It is reusable by the encryption core.

## Test plan
- n=33, d=7, cipher=31 (4^3 mod 33) -> out=4, err=0, down after E90, busy high E1..E90.
- n=255, d=255, cipher=254 -> out=254; latency 2+8*(8+8)=130 cycles.
- n=33, d=0, cipher=5 -> out=1 after 2+64 cycles; cipher=0 with d=3 -> out=0.
- Error operands: n=1 -> err=1, out=0, down after E2; cipher=40 with n=33 -> err=1; the next legal start clears err.
- Assert rst at cycle 30 of a run -> outputs 0 at once, IDLE. A fresh start (n=33, d=7, cipher=31) then yields 4.
- start pulsed at E10 during a run -> ignored, result unchanged. start asserted during the down cycle -> accepted next edge, second result correct.
